ndro_bank_rsfq: RTL and testbench

Parametrised bank of DEPTH words × WIDTH bits built from clocked NDRO-style storage cells. Each word has bitwise set and clear ports and a clocked read port. Read is non-destructive by default, with an optional destructive (DRO) mode. Used as multi-bit state storage in RSFQ controller netlists, replacing hand-instanced single-bit NDROT_RSFQ arrays for synthesis.

---
 rtl/rsfq_pkg.sv | 20 ++
 rtl/ndro_word_rsfq.sv | 46 ++++
 rtl/ndro_bank_rsfq.sv | 82 ++++++++
 tb/tb_ndro_bank_rsfq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rsfq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rsfq_pkg                                                                   |
// | Shared constants and helpers for RSFQ-style storage banks.                 |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package rsfq_pkg;

  localparam int RSFQ_NDRO = 0;
  localparam int RSFQ_DRO  = 1;
  localparam int CLR_WINS  = 1;
  localparam int SET_WINS  = 0;

  // A one-word bank still needs a one-bit address port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ndro_word_rsfq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ndro_word_rsfq                                                             |
// | One WIDTH-bit NDRO storage word with bitwise set/clear and a DRO strobe.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ndro_word_rsfq
  import rsfq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CLEAR_WINS = CLR_WINS
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] clr_i,
  input  logic             dro_clr_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] w_base;

  // The destructive clear acts first, so a same-cycle set survives it.
  always_comb begin
    w_base = dro_clr_i ? '0 : word_q;
    if (CLEAR_WINS != 0) begin
      word_d = (w_base | set_i) & ~clr_i;
    end else begin
      word_d = (w_base & ~clr_i) | set_i;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule
`default_nettype wire

// File: rtl/ndro_bank_rsfq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ndro_bank_rsfq                                                             |
// | DEPTH x WIDTH NDRO bank: address decode, read mux and registered Q/QV.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ndro_bank_rsfq
  import rsfq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int DESTRUCTIVE = RSFQ_NDRO,
  parameter int CLEAR_WINS  = CLR_WINS,
  localparam int AW         = clog2_min1(DEPTH)
) (
  input  logic             C,
  input  logic             R,
  input  logic             SV,
  input  logic [AW-1:0]    SA,
  input  logic [WIDTH-1:0] SD,
  input  logic             BV,
  input  logic [AW-1:0]    BA,
  input  logic [WIDTH-1:0] BD,
  input  logic             RV,
  input  logic [AW-1:0]    RA,
  output logic [WIDTH-1:0] Q,
  output logic             QV
);

  logic [WIDTH-1:0] w_words [DEPTH];
  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] q_q;
  logic             qv_q;

  // Out-of-range addresses match no word, so they are naturally ignored.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic             w_dro;

    assign w_set = (SV && (SA == AW'(g))) ? SD : '0;
    assign w_clr = (BV && (BA == AW'(g))) ? BD : '0;
    assign w_dro = (DESTRUCTIVE != 0) && RV && (RA == AW'(g));

    ndro_word_rsfq #(
      .WIDTH      (WIDTH),
      .CLEAR_WINS (CLEAR_WINS)
    ) u_word (
      .C         (C),
      .R         (R),
      .set_i     (w_set),
      .clr_i     (w_clr),
      .dro_clr_i (w_dro),
      .word_o    (w_words[g])
    );
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RA == AW'(i)) begin
        w_rd_word = w_words[i];
      end
    end
  end

  // No read pulse means no output pulse: Q returns to zero rather than holding.
  always_ff @(posedge C) begin
    if (R) begin
      q_q  <= '0;
      qv_q <= 1'b0;
    end else begin
      qv_q <= RV;
      q_q  <= RV ? w_rd_word : '0;
    end
  end

  assign Q  = q_q;
  assign QV = qv_q;

endmodule
`default_nettype wire

// File: tb/tb_ndro_bank_rsfq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ndro_bank_rsfq                                                          |
// | Two banks (NDRO/clear-wins/depth 4 and DRO/set-wins/depth 3) on one bus.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_ndro_bank_rsfq;
  import rsfq_pkg::*;

  logic       C  = 1'b0;
  logic       R  = 1'b1;
  logic       SV = 1'b0;
  logic       BV = 1'b0;
  logic       RV = 1'b0;
  logic [1:0] SA = '0;
  logic [1:0] BA = '0;
  logic [1:0] RA = '0;
  logic [7:0] SD = '0;
  logic [7:0] BD = '0;
  logic [7:0] qa, qb;
  logic       qva, qvb;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  ndro_bank_rsfq #(
    .WIDTH(8), .DEPTH(4), .DESTRUCTIVE(RSFQ_NDRO), .CLEAR_WINS(CLR_WINS)
  ) u_a (
    .C(C), .R(R), .SV(SV), .SA(SA), .SD(SD), .BV(BV), .BA(BA), .BD(BD),
    .RV(RV), .RA(RA), .Q(qa), .QV(qva)
  );

  ndro_bank_rsfq #(
    .WIDTH(8), .DEPTH(3), .DESTRUCTIVE(RSFQ_DRO), .CLEAR_WINS(SET_WINS)
  ) u_b (
    .C(C), .R(R), .SV(SV), .SA(SA), .SD(SD), .BV(BV), .BA(BA), .BD(BD),
    .RV(RV), .RA(RA), .Q(qb), .QV(qvb)
  );

  always #5 C = ~C;

  // Reference model: bank k has depth_k words, mode dro_k, priority cw_k.
  int         depth_k [2] = '{4, 3};
  bit         dro_k   [2] = '{1'b0, 1'b1};
  bit         cw_k    [2] = '{1'b1, 1'b0};
  logic [7:0] mem [2][4];
  logic [7:0] eq  [2];
  logic       eqv [2];

  always @(posedge C) begin
    logic [7:0] v, s, b;
    for (int k = 0; k < 2; k++) begin
      if (R) begin
        for (int w = 0; w < 4; w++) mem[k][w] = 8'h00;
        eq[k]  = 8'h00;
        eqv[k] = 1'b0;
      end else begin
        eqv[k] = RV;
        eq[k]  = (RV && int'(RA) < depth_k[k]) ? mem[k][RA] : 8'h00;
        for (int w = 0; w < depth_k[k]; w++) begin
          v = mem[k][w];
          if (dro_k[k] && RV && int'(RA) == w) v = 8'h00;
          s = (SV && int'(SA) == w) ? SD : 8'h00;
          b = (BV && int'(BA) == w) ? BD : 8'h00;
          mem[k][w] = cw_k[k] ? ((v | s) & ~b) : ((v & ~b) | s);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge C) begin
    if (started) begin
      check("model A.Q",  qa,  eq[0]);
      check("model A.QV", {7'b0, qva}, {7'b0, eqv[0]});
      check("model B.Q",  qb,  eq[1]);
      check("model B.QV", {7'b0, qvb}, {7'b0, eqv[1]});
    end
  end

  task automatic cyc(input bit r, input bit sv, input int sa, input logic [7:0] sd,
                     input bit bv, input int ba, input logic [7:0] bd,
                     input bit rv, input int ra);
    R  = r;
    SV = sv; SA = 2'(sa); SD = sd;
    BV = bv; BA = 2'(ba); BD = bd;
    RV = rv; RA = 2'(ra);
    @(negedge C);
  endtask

  task automatic rd(input int ra);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, ra);
  endtask

  task automatic st(input int sa, input logic [7:0] sd);
    cyc(0, 1, sa, sd, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    @(negedge C);
    started = 1'b1;
    check("reset A.Q",  qa, 8'h00);
    check("reset A.QV", {7'b0, qva}, 8'h00);

    for (int a = 0; a < 4; a++) begin
      rd(a);
      check("post-reset A.Q",  qa, 8'h00);
      check("post-reset A.QV", {7'b0, qva}, 8'h01);
      check("post-reset B.QV", {7'b0, qvb}, 8'h01);
    end

    rd(0);
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    check("reset-over-read A.QV", {7'b0, qva}, 8'h00);
    check("reset-over-read B.QV", {7'b0, qvb}, 8'h00);

    st(2, 8'hA5);
    rd(2);
    check("set-read A.Q", qa, 8'hA5);
    check("set-read B.Q", qb, 8'hA5);
    rd(2);
    check("ndro reread A.Q", qa, 8'hA5);
    check("dro reread B.Q",  qb, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("idle A.Q",  qa, 8'h00);
    check("idle A.QV", {7'b0, qva}, 8'h00);

    st(1, 8'h30);
    cyc(0, 1, 1, 8'h0F, 0, 0, 8'h00, 1, 1);
    check("rbw A.Q", qa, 8'h30);
    check("rbw B.Q", qb, 8'h30);
    rd(1);
    check("rbw after A.Q", qa, 8'h3F);
    check("rbw after B.Q", qb, 8'h0F);

    cyc(0, 1, 0, 8'hFF, 1, 0, 8'h0F, 0, 0);
    rd(0);
    check("clear-wins A.Q", qa, 8'hF0);
    check("set-wins B.Q",   qb, 8'hFF);

    st(2, 8'h81);
    rd(2);
    check("dro first B.Q", qb, 8'h81);
    rd(2);
    check("dro second B.Q", qb, 8'h00);
    st(2, 8'h81);
    cyc(0, 1, 2, 8'h02, 0, 0, 8'h00, 1, 2);
    check("dro+set first B.Q", qb, 8'h81);
    rd(2);
    check("dro+set second B.Q", qb, 8'h02);
    check("ndro accum A.Q",     qa, 8'hA7);

    st(3, 8'hFF);
    rd(3);
    check("addr3 A.Q",  qa, 8'hFF);
    check("oor B.Q",    qb, 8'h00);
    check("oor B.QV",   {7'b0, qvb}, 8'h01);

    st(0, 8'h11);
    st(1, 8'h22);
    st(2, 8'h33);
    rd(0);
    check("b2b0 B.Q", qb, 8'h11);
    rd(1);
    check("b2b1 B.Q", qb, 8'h22);
    check("b2b1 B.QV", {7'b0, qvb}, 8'h01);
    rd(2);
    check("b2b2 B.Q", qb, 8'h33);
    check("b2b2 A.Q", qa, 8'hB7);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
